// File: rtl/hazard_pkg.sv
// Shared constants for the scoreboard hazard unit: operand use stages and stall causes.
package hazard_pkg;

   localparam logic [1:0] USE_ID   = 2'd0;
   localparam logic [1:0] USE_EX   = 2'd1;
   localparam logic [1:0] USE_MEM  = 2'd2;
   localparam logic [1:0] USE_NONE = 2'd3;

   localparam logic [1:0] CAUSE_NONE   = 2'd0;
   localparam logic [1:0] CAUSE_DATA   = 2'd1;
   localparam logic [1:0] CAUSE_BRANCH = 2'd2;

   // A source hazards while its producer needs more cycles than the consumer's stage offset.
   function automatic logic src_hazard(input logic [2:0] cnt, input logic [1:0] use_stage,
                                       input logic idx_nz);
      return (use_stage != USE_NONE) && idx_nz && (cnt > {1'b0, use_stage});
   endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// Decode-stage <-> hazard unit bundle; HAZARD_STATS_EN adds the stall statistics outputs.
interface scoreboard_hazard_unit_if #(
   parameter int unsigned NUM_REGS = 32
);
   localparam int unsigned REG_W = $clog2(NUM_REGS);

   logic             idValid;
   logic [REG_W-1:0] idRs;
   logic [REG_W-1:0] idRt;
   logic [1:0]       idUseRs;
   logic [1:0]       idUseRt;
   logic             idRegWrite;
   logic [REG_W-1:0] idWriteReg;
   logic             idIsLoad;
   logic             branchTaken;
   logic             pcHold;
   logic             ifidHold;
   logic             idexBubble;
   logic             ifidFlush;
   logic [1:0]       stallCause;
`ifdef HAZARD_STATS_EN
   logic [31:0]      stallCycles;
   logic [31:0]      branchStallCycles;
`endif

   modport master (
      output idValid, idRs, idRt, idUseRs, idUseRt, idRegWrite, idWriteReg, idIsLoad,
             branchTaken,
`ifdef HAZARD_STATS_EN
      input  stallCycles, branchStallCycles,
`endif
      input  pcHold, ifidHold, idexBubble, ifidFlush, stallCause
   );

   modport slave (
      input  idValid, idRs, idRt, idUseRs, idUseRt, idRegWrite, idWriteReg, idIsLoad,
             branchTaken,
`ifdef HAZARD_STATS_EN
      output stallCycles, branchStallCycles,
`endif
      output pcHold, ifidHold, idexBubble, ifidFlush, stallCause
   );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown of cycles until an in-flight result is forwardable, two read ports.
module hazard_scoreboard #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ALU_LAT  = 1,
   parameter int unsigned LOAD_LAT = 2,
   parameter int unsigned CNT_W    = 2,
   parameter int unsigned REG_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [REG_W-1:0] wr_idx_i,
   input  logic             wr_load_i,
   input  logic [REG_W-1:0] rd_a_idx_i,
   input  logic [REG_W-1:0] rd_b_idx_i,
   output logic [CNT_W-1:0] rd_a_cnt_o,
   output logic [CNT_W-1:0] rd_b_cnt_o
);

   localparam logic [CNT_W-1:0] AluVal  = CNT_W'(ALU_LAT);
   localparam logic [CNT_W-1:0] LoadVal = CNT_W'(LOAD_LAT);

   logic [CNT_W-1:0] cnt_q [NUM_REGS];
   logic [CNT_W-1:0] cnt_d [NUM_REGS];
   logic [CNT_W-1:0] wr_val;

   assign wr_val = wr_load_i ? LoadVal : AluVal;

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
         // Issue write wins over the decrement and replaces any pending value (WAW).
         if (wr_en_i && (wr_idx_i == REG_W'(r))) begin
            cnt_d[r] = wr_val;
         end
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rd_a_cnt_o = cnt_q[rd_a_idx_i];
   assign rd_b_cnt_o = cnt_q[rd_b_idx_i];

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Decode-side hazard unit: stall/flush decisions from the register scoreboard.
// Optional stall statistics outputs are built when HAZARD_STATS_EN is defined.
module scoreboard_hazard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ALU_LAT  = 1,
   parameter int unsigned LOAD_LAT = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   scoreboard_hazard_unit_if.slave  bus
);

   localparam int unsigned REG_W = $clog2(NUM_REGS);
   localparam int unsigned CNT_W = $clog2(LOAD_LAT + 1);

   logic [CNT_W-1:0] cnt_rs;
   logic [CNT_W-1:0] cnt_rt;
   logic             haz_rs;
   logic             haz_rt;
   logic             branch_haz;
   logic             stall;
   logic             issue;

   hazard_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ALU_LAT  (ALU_LAT),
      .LOAD_LAT (LOAD_LAT),
      .CNT_W    (CNT_W),
      .REG_W    (REG_W)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (issue && bus.idRegWrite && (bus.idWriteReg != '0)),
      .wr_idx_i   (bus.idWriteReg),
      .wr_load_i  (bus.idIsLoad),
      .rd_a_idx_i (bus.idRs),
      .rd_b_idx_i (bus.idRt),
      .rd_a_cnt_o (cnt_rs),
      .rd_b_cnt_o (cnt_rt)
   );

   assign haz_rs     = src_hazard(3'(cnt_rs), bus.idUseRs, bus.idRs != '0);
   assign haz_rt     = src_hazard(3'(cnt_rt), bus.idUseRt, bus.idRt != '0);
   assign branch_haz = (haz_rs && (bus.idUseRs == USE_ID)) || (haz_rt && (bus.idUseRt == USE_ID));

   // Outputs are forced low while reset is asserted so a held stall releases at once.
   assign stall = rst_n && bus.idValid && (haz_rs || haz_rt);
   assign issue = bus.idValid && !stall;

   assign bus.pcHold     = stall;
   assign bus.ifidHold   = stall;
   assign bus.idexBubble = stall;
   assign bus.ifidFlush  = rst_n && bus.branchTaken && !stall;
   assign bus.stallCause = !stall     ? CAUSE_NONE :
                           branch_haz ? CAUSE_BRANCH : CAUSE_DATA;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] br_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         br_cnt_q    <= '0;
      end else begin
         if (stall && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if ((bus.stallCause == CAUSE_BRANCH) && !(&br_cnt_q)) begin
            br_cnt_q <= br_cnt_q + 32'd1;
         end
      end
   end

   assign bus.stallCycles       = stall_cnt_q;
   assign bus.branchStallCycles = br_cnt_q;
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench: driver pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_scoreboard_hazard_unit;

   typedef struct {
      int         id;
      logic       stall;
      logic       flush;
      logic [1:0] cause;
   } exp_t;

   logic clk;
   logic rst_n;
   int   nchecks;
   int   nerr;
   int   step;
   exp_t exp_q [$];

   scoreboard_hazard_unit_if #(.NUM_REGS(32)) bus ();

   scoreboard_hazard_unit #(
      .NUM_REGS (32),
      .ALU_LAT  (1),
      .LOAD_LAT (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int id, input logic [31:0] act,
                      input logic [31:0] expv);
      nchecks++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, expv);
      end
   endtask

   // One ID-stage cycle: drive just after the edge and queue what the outputs must be.
   task automatic cyc(input logic v, input int rs, input int rt, input int urs, input int urt,
                      input logic rw, input int wr, input logic ld, input logic br,
                      input logic es, input logic ef, input int ec);
      exp_t e;
      @(posedge clk);
      #1;
      bus.idValid     = v;
      bus.idRs        = 5'(rs);
      bus.idRt        = 5'(rt);
      bus.idUseRs     = 2'(urs);
      bus.idUseRt     = 2'(urt);
      bus.idRegWrite  = rw;
      bus.idWriteReg  = 5'(wr);
      bus.idIsLoad    = ld;
      bus.branchTaken = br;
      step++;
      e.id    = step;
      e.stall = es;
      e.flush = ef;
      e.cause = 2'(ec);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pcHold", e.id, 32'(bus.pcHold), 32'(e.stall));
            chk("ifidHold", e.id, 32'(bus.ifidHold), 32'(e.stall));
            chk("idexBubble", e.id, 32'(bus.idexBubble), 32'(e.stall));
            chk("ifidFlush", e.id, 32'(bus.ifidFlush), 32'(e.flush));
            chk("stallCause", e.id, 32'(bus.stallCause), 32'(e.cause));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : driver
      nchecks = 0;
      nerr    = 0;
      step    = 0;
      rst_n   = 1'b0;
      bus.idValid = 1'b1; bus.idRs = 5'd1; bus.idRt = 5'd2;
      bus.idUseRs = 2'd0; bus.idUseRt = 2'd0; bus.idRegWrite = 1'b0;
      bus.idWriteReg = 5'd0; bus.idIsLoad = 1'b0; bus.branchTaken = 1'b1;
      #3;
      chk("reset_pcHold", 0, 32'(bus.pcHold), 32'd0);
      chk("reset_ifidFlush", 0, 32'(bus.ifidFlush), 32'd0);
      chk("reset_stallCause", 0, 32'(bus.stallCause), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // lw $7 then add rs=$7 (EX use): one data stall.
      cyc(1, 2, 0, 1, 3, 1, 7, 1, 0, 0, 0, 0);
      cyc(1, 7, 8, 1, 1, 1, 10, 0, 0, 1, 0, 1);
      cyc(1, 7, 8, 1, 1, 1, 10, 0, 0, 0, 0, 0);
      idle(3);

      // add $22 then taken beq on $22: one branch stall, then a single flush cycle.
      cyc(1, 4, 0, 1, 3, 1, 22, 0, 0, 0, 0, 0);
      cyc(1, 22, 5, 0, 0, 0, 0, 0, 1, 1, 0, 2);
      cyc(1, 22, 5, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      idle(3);

      // lw $1 then taken beq on rt=$1: two branch stalls, no flush while stalled.
      cyc(1, 2, 0, 1, 3, 1, 1, 1, 0, 0, 0, 0);
      cyc(1, 6, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2);
      cyc(1, 6, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2);
      cyc(1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      idle(3);

`ifdef HAZARD_STATS_EN
      @(negedge clk);
      chk("stallCycles", step, bus.stallCycles, 32'd4);
      chk("branchStallCycles", step, bus.branchStallCycles, 32'd3);
`endif

      // lw $9 then sw with data $9 (MEM use) and clean base $3: no stall.
      cyc(1, 2, 0, 1, 3, 1, 9, 1, 0, 0, 0, 0);
      cyc(1, 3, 9, 1, 2, 0, 0, 0, 0, 0, 0, 0);
      idle(3);

      // Writes to $0 are never tracked.
      cyc(1, 2, 0, 1, 3, 1, 0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(3);

      // WAW: ALU write then load write to $12, consumer sees the load latency.
      cyc(1, 2, 0, 1, 3, 1, 12, 0, 0, 0, 0, 0);
      cyc(1, 2, 0, 1, 3, 1, 12, 1, 0, 0, 0, 0);
      cyc(1, 12, 0, 1, 3, 0, 0, 0, 0, 1, 0, 1);
      cyc(1, 12, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      idle(3);

      // No stall without a valid ID instruction, even on a hazarding source.
      cyc(1, 2, 0, 1, 3, 1, 13, 1, 0, 0, 0, 0);
      cyc(0, 13, 13, 1, 0, 0, 0, 0, 1, 0, 1, 0);
      idle(3);

      // Reset in the middle of a lw-beq stall releases at once and clears the scoreboard.
      cyc(1, 2, 0, 1, 3, 1, 1, 1, 0, 0, 0, 0);
      cyc(1, 6, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_pcHold", step, 32'(bus.pcHold), 32'd0);
      chk("rst_mid_idexBubble", step, 32'(bus.idexBubble), 32'd0);
      chk("rst_mid_ifidFlush", step, 32'(bus.ifidFlush), 32'd0);
      chk("rst_mid_stallCause", step, 32'(bus.stallCause), 32'd0);
`ifdef HAZARD_STATS_EN
      chk("rst_mid_stallCycles", step, bus.stallCycles, 32'd0);
`endif
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      idle(2);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         nchecks++;
         nerr++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule

// File: doc/scoreboard_hazard_unit.md
# scoreboard_hazard_unit

Parametrised scoreboard-based hazard detection unit for the 5-stage MIPS pipeline, sitting beside the decode stage.
- Tracks, per architectural register, the cycles remaining until an in-flight result becomes forwardable.
- Stalls the ID-stage instruction until every source it reads is available at the stage where it consumes it.
- Raises a flush of IF/ID on a taken branch.
- Generalises fixed lw-use / beq-after-ALU / beq-after-lw stall rules to configurable register count and producer latencies.

## Interface
- NUM_REGS, 32: architectural registers; index width REG_W = clog2(NUM_REGS).
- ALU_LAT, 1: cycles after issue before an ALU result can be forwarded to the ID comparator.
- LOAD_LAT, 2: same, for loads; LOAD_LAT >= ALU_LAT; both 1..7.
- CNT_W, clog2(LOAD_LAT+1): per-register counter width (derived, do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- idValid  in  1  ID stage holds a real instruction.
- idRs, idRt  in  REG_W  source register indices.
- idUseRs, idUseRt  in  2  stage where each source is consumed: 0=ID (branch compare), 1=EX, 2=MEM (sw data), 3=unused.
- idRegWrite  in  1  ID instruction writes a register.
- idWriteReg  in  REG_W  destination index.
- idIsLoad  in  1  ID instruction is a load.
- branchTaken  in  1  ID branch resolved taken; meaningful only when not stalled.
- pcHold  out  1  freeze PC.
- ifidHold  out  1  freeze IF/ID.
- idexBubble  out  1  load NOP control into ID/EX.
- ifidFlush  out  1  zero IF/ID next edge.
- stallCause  out  2  0=none, 1=EX/MEM-use data, 2=branch-operand data.

## Operation
- Scoreboard: cnt[r] per register, reset 0.
- Each cycle every nonzero cnt decrements by 1.
- Hazard on a source when use != 3, index != 0 and cnt[src] > use.
- stall = idValid && (hazard on Rs || hazard on Rt).
- pcHold = ifidHold = idexBubble = stall; all combinational.
- stallCause = 2 if any hazarding source has use 0, else 1 if stall, else 0.
- issue = idValid && !stall.
- On issue with idRegWrite and idWriteReg != 0: cnt[idWriteReg] <= idIsLoad ? LOAD_LAT : ALU_LAT.
  - The issue write overrides the same-cycle decrement.
  - A WAW overwrite replaces any nonzero value.
- ifidFlush = branchTaken && !stall. Flush does not cancel the branch's own issue.
- Register 0 is never tracked; writes to it are ignored.

## Timing
- Reset: all cnt 0; pcHold, ifidHold, idexBubble, ifidFlush 0; stallCause 0. Reset mid-stall releases immediately.
- Stall decision has zero latency: same cycle the consumer is in ID.
- Scoreboard update is visible the cycle after issue.
- Defaults give these stall counts:
  - lw then EX use: 1 cycle.
  - ALU then beq: 1 cycle.
  - lw then beq: 2 cycles.
  - lw then sw data (use 2): 0 cycles.
- Producer in EX when consumer arrives: no extra logic; cnt already holds the decremented value.
- Stall with idValid=0 never asserted.
- branchTaken during stall is ignored; the branch re-evaluates when operands are ready.

## Configuration
- HAZARD_STATS_EN defined:
  - adds output stallCycles (32 bit) and output branchStallCycles (32 bit), both saturating at all-ones.
  - stallCycles counts cycles with stall=1; branchStallCycles counts cycles with stallCause=2.
  - Both reset to 0.
- Undefined: counters and ports absent; all other behaviour identical.

## Structure
- Shared package hazard_pkg:
  - use-stage constants USE_ID, USE_EX, USE_MEM, USE_NONE;
  - stall-cause constants CAUSE_NONE, CAUSE_DATA, CAUSE_BRANCH.
- One sub-module, hazard_scoreboard:
  - holds the cnt array with decrement/issue-write logic;
  - two combinational read ports returning cnt for idRs and idRt.
- Top level holds the comparison, stall/flush logic and the optional stats counters.

## Test plan
- lw $7 issued, next ID add rs=$7 use=1 -> stall 1 cycle, idexBubble=1, stallCause=1, add issues on cycle 2.
- add $22 issued, next ID beq rs=$22 use=0 -> 1 stall cycle with stallCause=2; then beq taken -> ifidFlush=1 exactly one cycle.
- lw $1 issued, next beq rt=$1 -> stall cycles 2, ifidFlush never asserted while stalled.
- lw $9 then sw with data $9 use=2, base $3 clean -> no stall; writes to $0 followed by a $0 consumer -> no stall.
- rst_n low during a 2-cycle lw-beq stall -> outputs 0 asynchronously, scoreboard clear; after release, beq issues without stall.
- With HAZARD_STATS_EN, run the three stall cases above -> stallCycles=4, branchStallCycles=3.
